bcla_multiword_add_seq: RTL and testbench
=========================================

Name: bcla_multiword_add_seq

Overview:
- Multi-cycle sequencer that adds two WORDS×8-bit unsigned operands by time-sharing one 8-bit block carry look-ahead adder slice.
- Processes one 8-bit slice per cycle, LSB slice first, with the carry registered between slices.
- Sits between a valid/ready producer and a valid/ready consumer.
- Trades latency for area wherever a wide adder is not justified.

Parameters:
- WORDS, 4, number of 8-bit slices per operand (legal range 2..16).
- SLICE_W, 8, slice width. Fixed to 8 and not overridable; it matches the adder slice.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand pair and carry-in are valid
- in_ready  output  1  block accepts operands this cycle
- in_x  input  WORDS*8  operand X
- in_y  input  WORDS*8  operand Y
- in_cin  input  1  carry into slice 0
- out_valid  output  1  result is valid
- out_ready  input  1  consumer accepts the result
- out_s  output  WORDS*8+1  sum; the MSB is the final carry-out
- out_zero  output  1  out_s == 0
- busy  output  1  state != IDLE

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - state=IDLE, idx=0, carry=0.
  - Operand and result registers cleared, so out_s=0.
  - in_ready=1, out_valid=0, out_zero=0, busy=0.
- A reset assertion mid-operation aborts immediately. The partial result is discarded and no out_valid is produced.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at an edge: capture in_x, in_y; carry<=in_cin; idx<=0; clear result; go to RUN.
- RUN:
  - in_ready=0. The adder slice computes X[idx], Y[idx], carry.
  - Each edge: result slice idx <= slice sum[7:0]; carry <= slice sum[8]; idx <= idx+1.
  - When idx==WORDS-1: result bit WORDS*8 <= slice sum[8]; go to DONE.
  - Inputs are ignored while in RUN.
- DONE:
  - out_valid=1, out_s and out_zero stable, in_ready=0.
  - On out_ready: go to IDLE. out_valid drops the next cycle.
  - Backpressure: the block stays in DONE indefinitely with outputs unchanged.
- Latency:
  - Accept at edge E0; out_valid is high from E0+WORDS.
  - Minimum initiation interval is WORDS+2 cycles: DONE→IDLE costs one cycle, and there is no DONE-to-RUN bypass.
- in_valid arriving during RUN or DONE is not consumed; the producer holds it.
- out_zero is registered. It is computed from the final result when entering DONE and is valid only while out_valid=1.
- Width rules:
  - idx is clog2(WORDS) bits and never wraps past WORDS-1.
  - The sum is unsigned modulo 2^(WORDS*8+1), so it never overflows.
- All outputs are registered except in_ready and busy, which decode directly from state.

Decomposition:
- Shared package bcla_pkg:
  - SLICE_W=8 constant.
  - State typedef {IDLE, RUN, DONE}.
  - Helper function for the idx width.
- Sub-module bcla_slice_8 with interface (S[8:0], X[7:0], Y[7:0], Cin):
  - Combinational 8-bit block CLA: two 4-bit lookahead groups plus GP generators.
  - Cin is exposed as a port.
  - It is instantiated once; the sequencer muxes the slice operands by idx.

Test Plan:
- Reset then idle: check in_ready=1, out_valid=0, out_s=0, busy=0.
- Full carry ripple, WORDS=4: x=0xFFFFFFFF, y=0x00000001, cin=0.
  - Expect out_s=0x1_00000000 and out_zero=0.
  - out_valid rises exactly 4 cycles after the accept edge.
- Carry-in propagation: x=0x000000FF, y=0, cin=1 → out_s=0x0_00000100.
  - Then x=0xFFFFFFFF, y=0xFFFFFFFF, cin=1 → out_s=0x1_FFFFFFFF.
- Zero flag: x=0, y=0, cin=0 → out_s=0, out_zero=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE.
  - out_s is stable and in_ready stays 0 while in_valid is held high.
  - Release out_ready: the next operation is accepted 2 cycles later.
- Reset mid-RUN: assert rst_n=0 at idx=2 for one cycle.
  - All outputs return to reset values asynchronously.
  - No out_valid is ever seen for the aborted operation.
  - The next operation completes correctly.

Source files
------------

// File: rtl/bcla_pkg.sv
// Shared constants, FSM state type and width helper for the multi-word CLA adder.
package bcla_pkg;

    // Width of the single adder slice the sequencer time-shares.
    localparam int unsigned SLICE_W = 8;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bits needed to index WORDS slices. Never returns less than 1.
    function automatic int unsigned idx_w(input int unsigned words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/bcla_multiword_add_seq_if.sv
// Valid/ready operand and result bus of the multi-word adder sequencer.
interface bcla_multiword_add_seq_if
    import bcla_pkg::*;
#(
    parameter int unsigned WORDS = 4
);
    localparam int unsigned OP_W = WORDS * SLICE_W;

    logic            in_valid;
    logic            in_ready;
    logic [OP_W-1:0] in_x;
    logic [OP_W-1:0] in_y;
    logic            in_cin;
    logic            out_valid;
    logic            out_ready;
    logic [OP_W:0]   out_s;
    logic            out_zero;
    logic            busy;

    // Producer/consumer side.
    modport master (
        output in_valid, in_x, in_y, in_cin, out_ready,
        input  in_ready, out_valid, out_s, out_zero, busy
    );

    // Adder sequencer side.
    modport slave (
        input  in_valid, in_x, in_y, in_cin, out_ready,
        output in_ready, out_valid, out_s, out_zero, busy
    );

endinterface

// File: rtl/bcla_slice_8.sv
// Combinational 8-bit block carry look-ahead adder: two 4-bit lookahead groups
// combined through their group generate/propagate terms.
module bcla_slice_8
    import bcla_pkg::*;
(
    output logic [SLICE_W:0]   S,
    input  logic [SLICE_W-1:0] X,
    input  logic [SLICE_W-1:0] Y,
    input  logic               Cin
);

    // 4-bit lookahead group: returns {group_p, group_g, c[3:0]} with c[0] = ci.
    function automatic logic [5:0] cla4(input logic [3:0] g, input logic [3:0] p, input logic ci);
        logic [3:0] c;
        logic       gg;
        logic       gp;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        gp   = &p;
        return {gp, gg, c};
    endfunction

    logic [SLICE_W-1:0] g;
    logic [SLICE_W-1:0] p;
    logic [5:0]         lo;
    logic [5:0]         hi;
    logic               c4;
    logic               c8;

    assign g  = X & Y;
    assign p  = X ^ Y;
    assign lo = cla4(g[3:0], p[3:0], Cin);
    // Carry into the upper group straight from the lower group's G/P.
    assign c4 = lo[4] | (lo[5] & Cin);
    assign hi = cla4(g[7:4], p[7:4], c4);
    // Slice carry-out from both groups' G/P without waiting on c4.
    assign c8 = hi[4] | (hi[5] & lo[4]) | (hi[5] & lo[5] & Cin);
    assign S  = {c8, p ^ {hi[3:0], lo[3:0]}};

endmodule

// File: rtl/bcla_multiword_add_seq.sv
// Multi-word adder that time-shares one 8-bit CLA slice, LSB slice first,
// with the inter-slice carry held in a register.
module bcla_multiword_add_seq
    import bcla_pkg::*;
#(
    parameter int unsigned WORDS = 4
)
(
    input  logic                        clk,
    input  logic                        rst_n,
    bcla_multiword_add_seq_if.slave     bus
);

    localparam int unsigned     IDX_W    = idx_w(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    state_e                         state_q;
    state_e                         state_d;
    logic [IDX_W-1:0]               idx_q;
    logic [IDX_W-1:0]               idx_d;
    logic                           carry_q;
    logic                           carry_d;
    logic [WORDS-1:0][SLICE_W-1:0]  x_q;
    logic [WORDS-1:0][SLICE_W-1:0]  x_d;
    logic [WORDS-1:0][SLICE_W-1:0]  y_q;
    logic [WORDS-1:0][SLICE_W-1:0]  y_d;
    logic [WORDS-1:0][SLICE_W-1:0]  res_q;
    logic [WORDS-1:0][SLICE_W-1:0]  res_d;
    logic                           res_msb_q;
    logic                           res_msb_d;
    logic                           out_valid_q;
    logic                           out_valid_d;
    logic                           out_zero_q;
    logic                           out_zero_d;
    logic [SLICE_W:0]               slice_s;

    // The one shared adder slice, fed the operand slices selected by idx.
    bcla_slice_8 u_slice (
        .S   (slice_s),
        .X   (x_q[idx_q]),
        .Y   (y_q[idx_q]),
        .Cin (carry_q)
    );

    // Next-state and datapath updates for IDLE -> RUN -> DONE.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        x_d         = x_q;
        y_d         = y_q;
        res_d       = res_q;
        res_msb_d   = res_msb_q;
        out_valid_d = out_valid_q;
        out_zero_d  = out_zero_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    x_d        = bus.in_x;
                    y_d        = bus.in_y;
                    carry_d    = bus.in_cin;
                    idx_d      = '0;
                    res_d      = '0;
                    res_msb_d  = 1'b0;
                    out_zero_d = 1'b0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                res_d[idx_q] = slice_s[SLICE_W-1:0];
                carry_d      = slice_s[SLICE_W];
                if (idx_q == LAST_IDX) begin
                    // Last slice: its carry-out becomes the sum MSB.
                    res_msb_d   = slice_s[SLICE_W];
                    idx_d       = '0;
                    out_valid_d = 1'b1;
                    out_zero_d  = ({slice_s[SLICE_W], res_d} == '0);
                    state_d     = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // FSM state register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand, carry, index and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q       <= '0;
            carry_q     <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            res_q       <= '0;
            res_msb_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_zero_q  <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            x_q         <= x_d;
            y_q         <= y_d;
            res_q       <= res_d;
            res_msb_q   <= res_msb_d;
            out_valid_q <= out_valid_d;
            out_zero_q  <= out_zero_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_s     = {res_msb_q, res_q};
    assign bus.out_zero  = out_zero_q;

endmodule

// File: tb/tb_bcla_multiword_add_seq.sv
// Bench for the multi-word sequential CLA adder: directed vectors, backpressure,
// mid-operation reset and random operands against an arithmetic model.
module tb_bcla_multiword_add_seq;

    localparam int unsigned WORDS = 4;
    localparam int unsigned W     = WORDS * 8;

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         cin;
        logic [W:0]   s;
        logic         z;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    vec_t vecs[6];

    bcla_multiword_add_seq_if #(.WORDS(WORDS)) bus ();

    bcla_multiword_add_seq #(.WORDS(WORDS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [W:0] ref_sum(input logic [W-1:0] x, input logic [W-1:0] y, input logic cin);
        return {1'b0, x} + {1'b0, y} + (W+1)'(cin);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One full transaction: present operands, wait for accept, wait for result,
    // hold the result for 'hold' extra cycles, then consume it.
    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic cin,
                         input int hold, output logic [W:0] s, output logic z, output int lat);
        int guard;
        s   = '0;
        z   = 1'b0;
        lat = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_x     = x;
        bus.in_y     = y;
        bus.in_cin   = cin;
        guard = 0;
        while (!bus.in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.in_ready) check("accept_timeout", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        while (!bus.out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        s = bus.out_s;
        z = bus.out_zero;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_stable", 64'(bus.out_s), 64'(s));
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("valid_drop", 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        logic [W:0]   s;
        logic         z;
        int           lat;
        logic [W-1:0] rx;
        logic [W-1:0] ry;
        logic         rc;
        logic [W:0]   exp_s;
        logic         seen;
        int           guard;

        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_x      = '0;
        bus.in_y      = '0;
        bus.in_cin    = 1'b0;
        bus.out_ready = 1'b0;

        vecs[0] = '{x: 32'hFFFF_FFFF, y: 32'h0000_0001, cin: 1'b0, s: 33'h1_0000_0000, z: 1'b0};
        vecs[1] = '{x: 32'h0000_00FF, y: 32'h0000_0000, cin: 1'b1, s: 33'h0_0000_0100, z: 1'b0};
        vecs[2] = '{x: 32'hFFFF_FFFF, y: 32'hFFFF_FFFF, cin: 1'b1, s: 33'h1_FFFF_FFFF, z: 1'b0};
        vecs[3] = '{x: 32'h0000_0000, y: 32'h0000_0000, cin: 1'b0, s: 33'h0_0000_0000, z: 1'b1};
        vecs[4] = '{x: 32'h1234_5678, y: 32'h0FED_CBA9, cin: 1'b0, s: 33'h0_2222_2221, z: 1'b0};
        vecs[5] = '{x: 32'h0000_0000, y: 32'h0000_0000, cin: 1'b1, s: 33'h0_0000_0001, z: 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready",  64'(bus.in_ready),  64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_s",     64'(bus.out_s),     64'd0);
        check("rst_busy",      64'(bus.busy),      64'd0);
        check("rst_out_zero",  64'(bus.out_zero),  64'd0);

        // Directed vector table
        for (int i = 0; i < 6; i++) begin
            do_op(vecs[i].x, vecs[i].y, vecs[i].cin, 1, s, z, lat);
            check($sformatf("vec%0d_s", i),   64'(s),   64'(vecs[i].s));
            check($sformatf("vec%0d_z", i),   64'(z),   64'(vecs[i].z));
            check($sformatf("vec%0d_lat", i), 64'(lat), 64'(WORDS));
        end

        // Backpressure: result held 10 cycles while a new request waits
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_x     = 32'h8000_0001;
        bus.in_y     = 32'h8000_00FF;
        bus.in_cin   = 1'b0;
        exp_s        = ref_sum(32'h8000_0001, 32'h8000_00FF, 1'b0);
        check("bp_idle_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_x   = 32'h0F0F_0F0F;
        bus.in_y   = 32'hF0F0_F0F0;
        bus.in_cin = 1'b1;
        guard = 0;
        while (!bus.out_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("bp_lat", 64'(guard), 64'(WORDS));
        for (int c = 0; c < 10; c++) begin
            check("bp_out_s",     64'(bus.out_s),     64'(exp_s));
            check("bp_in_ready",  64'(bus.in_ready),  64'd0);
            check("bp_out_valid", 64'(bus.out_valid), 64'd1);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("bp_rel_valid", 64'(bus.out_valid), 64'd0);
        check("bp_rel_ready", 64'(bus.in_ready),  64'd1);
        @(negedge clk);
        check("bp_next_busy", 64'(bus.busy), 64'd1);
        bus.in_valid = 1'b0;
        exp_s = ref_sum(32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b1);
        guard = 0;
        while (!bus.out_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("bp_next_s", 64'(bus.out_s), 64'(exp_s));
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;

        // Reset asserted mid-RUN at idx 2
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_x     = 32'hDEAD_BEEF;
        bus.in_y     = 32'h1111_1111;
        bus.in_cin   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_busy_before", 64'(bus.busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready",  64'(bus.in_ready),  64'd1);
        check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_busy",      64'(bus.busy),      64'd0);
        check("mid_rst_out_s",     64'(bus.out_s),     64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            seen = seen | bus.out_valid;
        end
        check("mid_no_valid", 64'(seen), 64'd0);
        do_op(32'hDEAD_BEEF, 32'h1111_1111, 1'b1, 0, s, z, lat);
        check("mid_after_s",   64'(s),   64'(ref_sum(32'hDEAD_BEEF, 32'h1111_1111, 1'b1)));
        check("mid_after_lat", 64'(lat), 64'(WORDS));

        // Random operands against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            rx = $urandom;
            ry = $urandom;
            rc = 1'($urandom_range(0, 1));
            if (i % 8 == 3) rx = '1;
            if (i % 8 == 5) ry = ~rx;
            exp_s = ref_sum(rx, ry, rc);
            do_op(rx, ry, rc, int'($urandom_range(0, 3)), s, z, lat);
            check($sformatf("rnd%0d_s", i),   64'(s),   64'(exp_s));
            check($sformatf("rnd%0d_z", i),   64'(z),   64'(exp_s == '0));
            check($sformatf("rnd%0d_lat", i), 64'(lat), 64'(WORDS));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
